// File: rtl/mips_pkg.sv
// MIPS pipeline shared definitions.
// Opcode/funct/ALU codes, stage bundles and the main decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] simm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [4:0]  writereg;
  } mem_wb_t;

  // beq/j carry no datapath control; they are decoded separately.
  function automatic ctrl_t decode(input logic [5:0] op,
                                   input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        unique case (1'b1)
          fn == F_ADD: c.alucontrol = ALU_ADD;
          fn == F_SUB: c.alucontrol = ALU_SUB;
          fn == F_AND: c.alucontrol = ALU_AND;
          fn == F_OR:  c.alucontrol = ALU_OR;
          fn == F_SLT: c.alucontrol = ALU_SLT;
          default:     c = '0;
        endcase
      end
      op == OP_LW: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.alusrc     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      op == OP_SW: begin
        c.memwrite   = 1'b1;
        c.alusrc     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      op == OP_ADDI: begin
        c.regwrite   = 1'b1;
        c.alusrc     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_if.sv
// Instruction/data memory bus of the MIPS core.
// master = core (pc, memwrite, aluout, writedata out), slave = memories.
interface mips_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output pc, memwrite, aluout, writedata,
    input  instr, readdata
  );
  modport slave (
    input  pc, memwrite, aluout, writedata,
    output instr, readdata
  );
endinterface

// File: rtl/mips_eqcmp.sv
// 32-bit equality comparator for branch resolution in D.
// a_i, b_i -> eq_o.
module mips_eqcmp (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        eq_o
);
  assign eq_o = (a_i == b_i);
endmodule

// File: rtl/mips_flop.sv
// Generic pipeline register with enable and synchronous clear.
// clk/rst_n, en_i, clr_i (wins over en_i), d_i -> q_o.
module mips_flop #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      q_o <= '0;
    else if (clr_i)  q_o <= '0;
    else if (en_i)   q_o <= d_i;
endmodule

// File: rtl/mips_hazard.sv
// Forwarding selects and stall detection for the 5-stage pipeline.
// Register ids/controls of D,E,M,W in; fwd selects and stall out.
module mips_hazard (
  input  logic [4:0] rsD_i,
  input  logic [4:0] rtD_i,
  input  logic [4:0] rsE_i,
  input  logic [4:0] rtE_i,
  input  logic [4:0] wregE_i,
  input  logic [4:0] wregM_i,
  input  logic [4:0] wregW_i,
  input  logic       branchD_i,
  input  logic       regwriteE_i,
  input  logic       memtoregE_i,
  input  logic       regwriteM_i,
  input  logic       memtoregM_i,
  input  logic       regwriteW_i,
  output logic       fwdAD_o,
  output logic       fwdBD_o,
  output logic [1:0] fwdAE_o,
  output logic [1:0] fwdBE_o,
  output logic       stall_o
);
  function automatic logic hit_m(input logic [4:0] s);
    return s != 5'd0 && regwriteM_i && wregM_i == s;
  endfunction

  function automatic logic hit_w(input logic [4:0] s);
    return s != 5'd0 && regwriteW_i && wregW_i == s;
  endfunction

  logic lwstall, brstall, useE, useM;

  assign fwdAD_o = hit_m(rsD_i);
  assign fwdBD_o = hit_m(rtD_i);

  // 2'b10 = from M, 2'b01 = from W
  assign fwdAE_o = hit_m(rsE_i) ? 2'b10 :
                   hit_w(rsE_i) ? 2'b01 : 2'b00;
  assign fwdBE_o = hit_m(rtE_i) ? 2'b10 :
                   hit_w(rtE_i) ? 2'b01 : 2'b00;

  assign lwstall = memtoregE_i &&
                   (rtE_i == rsD_i || rtE_i == rtD_i);

  assign useE = regwriteE_i &&
                (wregE_i == rsD_i || wregE_i == rtD_i);
  assign useM = memtoregM_i &&
                (wregM_i == rsD_i || wregM_i == rtD_i);
  assign brstall = branchD_i && (useE || useM);

  assign stall_o = lwstall || brstall;
endmodule

// File: rtl/mips.sv
// Five-stage pipelined MIPS core (F/D/E/M/W), no delay slot.
// clk, reset (async, active-low), bus: mips_if master port.
module mips #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  mips_if.master bus
);
  import mips_pkg::*;

  logic [31:0] pc_q, pc_d, pcplus4F;
  logic        stall, flushD;
  if_id_t      ifid_d, ifid_q;
  id_ex_t      idex_d, idex_q;
  ex_mem_t     exmem_d, exmem_q;
  mem_wb_t     memwb_d, memwb_q;
  logic [31:0] resultW;

  // Fetch
  assign pcplus4F = pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset)
    if (!reset)      pc_q <= RESET_PC;
    else if (!stall) pc_q <= pc_d;

  assign bus.pc = pc_q;
  assign ifid_d = '{instr: bus.instr, pcplus4: pcplus4F};

  mips_flop #(.W($bits(if_id_t))) u_ifid (
    .clk(clk), .rst_n(reset),
    .en_i(!stall), .clr_i(flushD),
    .d_i(ifid_d), .q_o(ifid_q)
  );

  // Decode
  logic [5:0]  opD;
  logic [4:0]  rsD, rtD, rdD;
  logic [31:0] simmD, rd1D, rd2D, cmpA, cmpB;
  logic [31:0] pcbrD, pcjD;
  logic        branchD, jumpD, eqD, pcsrcD;
  logic        fwdAD, fwdBD;
  ctrl_t       ctrlD;
  logic [31:0] rf [32];

  assign opD   = ifid_q.instr[31:26];
  assign rsD   = ifid_q.instr[25:21];
  assign rtD   = ifid_q.instr[20:16];
  assign rdD   = ifid_q.instr[15:11];
  assign simmD = {{16{ifid_q.instr[15]}},
                  ifid_q.instr[15:0]};
  assign ctrlD   = decode(opD, ifid_q.instr[5:0]);
  assign branchD = (opD == OP_BEQ);
  assign jumpD   = (opD == OP_J);

  // Register file contents are deliberately not reset.
  always_ff @(posedge clk)
    if (memwb_q.regwrite && memwb_q.writereg != 5'd0)
      rf[memwb_q.writereg] <= resultW;

  // Same-cycle write-back bypass into the read ports.
  assign rd1D = (rsD == 5'd0) ? 32'd0 :
                (memwb_q.regwrite && memwb_q.writereg == rsD)
                  ? resultW : rf[rsD];
  assign rd2D = (rtD == 5'd0) ? 32'd0 :
                (memwb_q.regwrite && memwb_q.writereg == rtD)
                  ? resultW : rf[rtD];

  assign cmpA = fwdAD ? exmem_q.aluout : rd1D;
  assign cmpB = fwdBD ? exmem_q.aluout : rd2D;

  mips_eqcmp u_eq (.a_i(cmpA), .b_i(cmpB), .eq_o(eqD));

  assign pcsrcD = branchD && eqD;
  assign pcbrD  = ifid_q.pcplus4 + {simmD[29:0], 2'b00};
  assign pcjD   = {ifid_q.pcplus4[31:28],
                   ifid_q.instr[25:0], 2'b00};
  // Redirect only lands once the stall clears (pc held anyway).
  assign flushD = (pcsrcD || jumpD) && !stall;
  assign pc_d   = jumpD  ? pcjD  :
                  pcsrcD ? pcbrD : pcplus4F;

  assign idex_d = '{ctrl: ctrlD, rd1: rd1D, rd2: rd2D,
                    simm: simmD, rs: rsD, rt: rtD, rd: rdD};

  mips_flop #(.W($bits(id_ex_t))) u_idex (
    .clk(clk), .rst_n(reset),
    .en_i(1'b1), .clr_i(stall),
    .d_i(idex_d), .q_o(idex_q)
  );

  // Execute
  logic [1:0]  fwdAE, fwdBE;
  logic [31:0] srcAE, srcBE, wdE, aluE;
  logic [4:0]  wregE;

  assign srcAE = fwdAE[1] ? exmem_q.aluout :
                 fwdAE[0] ? resultW : idex_q.rd1;
  assign wdE   = fwdBE[1] ? exmem_q.aluout :
                 fwdBE[0] ? resultW : idex_q.rd2;
  assign srcBE = idex_q.ctrl.alusrc ? idex_q.simm : wdE;
  assign wregE = idex_q.ctrl.regdst ? idex_q.rd : idex_q.rt;

  always_comb begin
    unique case (idex_q.ctrl.alucontrol)
      ALU_AND: aluE = srcAE & srcBE;
      ALU_OR:  aluE = srcAE | srcBE;
      ALU_ADD: aluE = srcAE + srcBE;
      ALU_SUB: aluE = srcAE - srcBE;
      ALU_SLT: aluE = {31'd0,
                       $signed(srcAE) < $signed(srcBE)};
      default: aluE = 32'd0;
    endcase
  end

  assign exmem_d = '{regwrite:  idex_q.ctrl.regwrite,
                     memtoreg:  idex_q.ctrl.memtoreg,
                     memwrite:  idex_q.ctrl.memwrite,
                     aluout:    aluE,
                     writedata: wdE,
                     writereg:  wregE};

  mips_flop #(.W($bits(ex_mem_t))) u_exmem (
    .clk(clk), .rst_n(reset),
    .en_i(1'b1), .clr_i(1'b0),
    .d_i(exmem_d), .q_o(exmem_q)
  );

  // Memory
  assign bus.memwrite  = exmem_q.memwrite;
  assign bus.aluout    = exmem_q.aluout;
  assign bus.writedata = exmem_q.writedata;

  assign memwb_d = '{regwrite: exmem_q.regwrite,
                     memtoreg: exmem_q.memtoreg,
                     readdata: bus.readdata,
                     aluout:   exmem_q.aluout,
                     writereg: exmem_q.writereg};

  mips_flop #(.W($bits(mem_wb_t))) u_memwb (
    .clk(clk), .rst_n(reset),
    .en_i(1'b1), .clr_i(1'b0),
    .d_i(memwb_d), .q_o(memwb_q)
  );

  // Write-back
  assign resultW = memwb_q.memtoreg ? memwb_q.readdata
                                    : memwb_q.aluout;

  mips_hazard u_hz (
    .rsD_i(rsD), .rtD_i(rtD),
    .rsE_i(idex_q.rs), .rtE_i(idex_q.rt),
    .wregE_i(wregE),
    .wregM_i(exmem_q.writereg),
    .wregW_i(memwb_q.writereg),
    .branchD_i(branchD),
    .regwriteE_i(idex_q.ctrl.regwrite),
    .memtoregE_i(idex_q.ctrl.memtoreg),
    .regwriteM_i(exmem_q.regwrite),
    .memtoregM_i(exmem_q.memtoreg),
    .regwriteW_i(memwb_q.regwrite),
    .fwdAD_o(fwdAD), .fwdBD_o(fwdBD),
    .fwdAE_o(fwdAE), .fwdBE_o(fwdBE),
    .stall_o(stall)
  );
endmodule

// File: tb/tb_mips.sv
// Directed bench for the mips core.
// Small programs with hand-computed pc traces and store results.
module tb_mips;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_if bus();

  mips #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  assign bus.instr    = imem[bus.pc[7:2]];
  assign bus.readdata = dmem[bus.aluout[7:2]];

  always @(posedge clk)
    if (bus.memwrite)
      dmem[bus.aluout[7:2]] <= bus.writedata;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t         slog [$];
  logic [31:0] pcs [64];
  int          cyc;
  int          total = 0;
  int          bad   = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(int op, int s,
                                     int t, int imm);
    return {op[5:0], s[4:0], t[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] er(int s, int t,
                                     int d, int fn);
    return {6'd0, s[4:0], t[4:0], d[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] ej(int tg);
    return {6'h02, tg[27:2]};
  endfunction

  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic dset(int a, logic [31:0] v);
    dmem[a] <= v;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc < 64) pcs[cyc] = bus.pc;
    if (bus.memwrite)
      slog.push_back('{cyc, bus.aluout, bus.writedata});
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold reset three cycles, then release on a falling edge.
  task automatic boot();
    slog.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pc", bus.pc, 32'h0);
      check("rst_mw", {31'd0, bus.memwrite}, 32'd0);
    end
    check("rst_alu", bus.aluout, 32'd0);
    check("rst_wd", bus.writedata, 32'd0);
    reset = 1'b1;
    cyc = 0;
    pcs[0] = bus.pc;
  endtask

  task automatic chk_st(string t, int k, int c,
                        logic [31:0] a, logic [31:0] d);
    st_t e;
    e = '{-1, '1, '1};
    if (k < slog.size()) e = slog[k];
    check({t, "_cyc"}, e.c, c);
    check({t, "_addr"}, e.a, a);
    check({t, "_data"}, e.d, d);
  endtask

  initial begin
    clr_imem();
    for (int i = 0; i < 64; i++) dset(i, 32'd0);

    // sequential fetch out of reset
    reset = 1'b0;
    clr_imem();
    boot();
    check("seq_pc0", pcs[0], 32'd0);
    run(3);
    check("seq_pc1", pcs[1], 32'd4);
    check("seq_pc2", pcs[2], 32'd8);
    check("seq_pc3", pcs[3], 32'd12);
    check("seq_nost", slog.size(), 0);

    // M and W forwarding, no stall; then async reset
    reset = 1'b0;
    clr_imem();
    imem[0] = ei(8, 0, 2, 5);
    imem[1] = ei(8, 0, 3, 12);
    imem[2] = er(2, 3, 4, 32);
    imem[3] = ei(43, 0, 4, 84);
    boot();
    run(6);
    check("fw_pc4", pcs[4], 32'd16);
    chk_st("fw_st", 0, 6, 32'd84, 32'd17);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'd0);
    check("arst_mw", {31'd0, bus.memwrite}, 32'd0);
    check("arst_alu", bus.aluout, 32'd0);
    check("arst_wd", bus.writedata, 32'd0);

    // load-use stall
    clr_imem();
    dset(0, 32'd7);
    dset(2, 32'd0);
    imem[0] = ei(35, 0, 2, 0);
    imem[1] = er(2, 2, 3, 32);
    imem[2] = ei(43, 0, 3, 8);
    boot();
    run(10);
    check("lu_pc2", pcs[2], 32'd8);
    check("lu_pc3", pcs[3], 32'd8);
    check("lu_pc4", pcs[4], 32'd12);
    chk_st("lu_st", 0, 6, 32'd8, 32'd14);
    check("lu_mem", dmem[2], 32'd14);
    check("lu_nst", slog.size(), 1);

    // beq after producer: stall, then taken
    reset = 1'b0;
    clr_imem();
    imem[0] = ei(8, 0, 2, 3);
    imem[1] = ei(8, 0, 6, 6);
    imem[2] = ei(8, 0, 7, 2);
    imem[3] = er(2, 2, 5, 32);
    imem[4] = ei(4, 5, 6, 2);
    imem[5] = ei(8, 0, 7, 99);
    imem[6] = ei(8, 0, 7, 98);
    imem[7] = ei(43, 0, 7, 44);
    imem[8] = ei(43, 0, 5, 40);
    boot();
    run(14);
    check("br_pc5", pcs[5], 32'd20);
    check("br_pc6", pcs[6], 32'd20);
    check("br_pc7", pcs[7], 32'd28);
    chk_st("br_st7", 0, 10, 32'd44, 32'd2);
    chk_st("br_st5", 1, 11, 32'd40, 32'd6);
    check("br_nst", slog.size(), 2);

    // jump squashes the next instruction; $7 still 2
    reset = 1'b0;
    clr_imem();
    imem[0] = ej(16);
    imem[1] = ei(8, 0, 7, 1);
    imem[4] = ei(43, 0, 7, 0);
    boot();
    run(8);
    check("j_pc1", pcs[1], 32'd4);
    check("j_pc2", pcs[2], 32'd16);
    chk_st("j_st", 0, 5, 32'd0, 32'd2);
    check("j_nst", slog.size(), 1);

    // writes to $0 are dropped and never forwarded
    reset = 1'b0;
    clr_imem();
    imem[0] = ei(8, 0, 0, 9);
    imem[1] = ei(43, 0, 0, 0);
    boot();
    run(6);
    chk_st("r0_st", 0, 4, 32'd0, 32'd0);

    // ALU ops, signed slt, unsupported funct is a NOP
    reset = 1'b0;
    clr_imem();
    for (int i = 0; i < 6; i++) dset(i, 32'hDEADBEEF);
    imem[0]  = ei(8, 0, 2, 'hFFFD);
    imem[1]  = ei(8, 0, 3, 5);
    imem[2]  = er(2, 3, 4, 34);
    imem[3]  = er(2, 3, 5, 42);
    imem[4]  = er(2, 3, 6, 36);
    imem[5]  = er(2, 3, 8, 37);
    imem[6]  = ei(43, 0, 4, 0);
    imem[7]  = ei(43, 0, 5, 4);
    imem[8]  = ei(43, 0, 6, 8);
    imem[9]  = ei(43, 0, 8, 12);
    imem[10] = er(3, 2, 9, 42);
    imem[11] = ei(43, 0, 9, 16);
    imem[12] = er(2, 3, 5, 39);
    imem[13] = ei(43, 0, 5, 20);
    boot();
    run(20);
    check("alu_sub", dmem[0], 32'hFFFF_FFF8);
    check("alu_slt1", dmem[1], 32'd1);
    check("alu_and", dmem[2], 32'd5);
    check("alu_or", dmem[3], 32'hFFFF_FFFD);
    check("alu_slt0", dmem[4], 32'd0);
    check("alu_nop", dmem[5], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded while reset is asserted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 pc  output  32  fetch address (byte address, word-aligned).
REQ-005 instr  input  32  instruction word for pc (combinational instruction memory).
REQ-006 memwrite  output  1  data-memory write strobe (Memory stage).
REQ-007 aluout  output  32  data-memory byte address / ALU result (Memory stage).
REQ-008 writedata  output  32  store data (Memory stage).
REQ-009 readdata  input  32  load data for aluout (combinational data memory, same cycle).

Function
REQ-010 Five-stage pipeline F/D/E/M/W; one instruction issued per cycle absent stalls; no branch delay slot.
REQ-011 Supported: R-type add(0x20), sub(0x22), and(0x24), or(0x25), slt(0x2A); lw(0x23), sw(0x2B), beq(0x04), addi(0x08), j(0x02); every other opcode/funct executes as a NOP (no register or memory write).
REQ-012 ALU control: and=000, or=001, add=010, sub=110, slt=111; slt signed, result 1/0; arithmetic modulo 2^32, no overflow trap.
REQ-013 Immediates sign-extended 16->32; branch target = (pc+4 of beq) + (simm<<2); jump target = {pc+4[31:28], instr[25:0], 2'b00}.
REQ-014 beq resolved in D with 32-bit equality comparator (eqcmp); taken branch or j redirects PC next cycle and squashes the instruction in F (D register cleared).
REQ-015 Register file 32x32, 2 read / 1 write; $0 reads 0, writes to $0 ignored; same-cycle write/read of one register returns write data (internal bypass).
REQ-016 E-stage forwarding per source: from M if regwriteM, writeregM==src, src!=0; else from W under same rule; else register value; M has priority.
REQ-017 D-stage forwarding (branch operands): from M ALU result if regwriteM, writeregM==src, src!=0.
REQ-018 Load-use stall: lw in E with rtE==rsD or rtE==rtD -> hold PC and D, insert bubble in E (one cycle).
REQ-019 Branch stall: beq in D and (regwriteE and writeregE in {rsD,rtD}) or (memtoregM and writeregM in {rsD,rtD}) -> same hold/bubble.
REQ-020 During a stall, branch/jump redirect and D flush are suppressed; they take effect when the stall clears.
REQ-021 Bubbles carry all control signals 0; memwrite only asserted for sw in M.
REQ-022 Write-back selects readdata (lw) or ALU result; destination rd for R-type, rt for lw/addi.

Reset
REQ-023 While reset=0: pc=RESET_PC, all pipeline registers 0 (NOPs), memwrite=0, aluout=0, writedata=0; register file contents not reset.
REQ-024 Reset asserted mid-operation aborts all in-flight instructions immediately; fetch restarts at RESET_PC on first rising edge after release.

Structure
REQ-025 Shared package holds opcode, funct and ALU-control constants.
REQ-026 Hazard/forwarding logic in one sub-module mips_hazard; pipeline registers built from a generic enable/clear flop; eqcmp a trivial combinational comparator.

Verification
REQ-027 Hold reset=0 three cycles, release -> pc 0, then 4, 8, 12; memwrite=0 throughout reset.
REQ-028 addi $2,$0,5; addi $3,$0,12; add $4,$2,$3; sw $4,84($0) -> memwrite=1, aluout=84, writedata=17 (forwarding, no stall).
REQ-029 lw $2,0($0) (mem[0]=7); add $3,$2,$2; sw $3,8($0) -> pc holds one cycle; store writes 14 to address 8.
REQ-030 add $5,$2,$2 then beq $5,$6,+2 with equal values -> one stall cycle, pc = branch target, instruction after beq never writes.
REQ-031 j 0x10 at pc 0 followed by addi $7,$0,1 -> pc becomes 0x10, $7 unchanged.
REQ-032 addi $0,$0,9; sw $0,0($0) -> writedata=0.
